id_regfile_hazard: RTL and testbench
====================================

Name: id_regfile_hazard

Overview:
- Decode-stage register file with an in-order scoreboard.
- Its read ports drive the operand source_data inputs of the ID/EX operand registers. Its write port is the write-back end of the same operand path.
- Tracks destinations in flight and raises stall when an issuing instruction would read a register that has a pending write (RAW) or would re-target one (WAW).
- Sits between the WB stage and the ID/EX register boundary.

Parameters:
- DATA_WIDTH, 32, width of each register and of the read/write data.
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- rs_addr  in  ADDR_WIDTH  source A index.
- rt_addr  in  ADDR_WIDTH  source B index.
- rs_used  in  1  current ID instruction reads rs.
- rt_used  in  1  current ID instruction reads rt.
- rs_data  out  DATA_WIDTH  operand A; feeds the ID/EX A register.
- rt_data  out  DATA_WIDTH  operand B; feeds the ID/EX B register.
- issue_valid  in  1  ID holds a valid instruction that wants to advance this cycle.
- issue_dest_en  in  1  that instruction writes a register.
- issue_dest  in  ADDR_WIDTH  destination index.
- wb_en  in  1  write-back valid.
- wb_addr  in  ADDR_WIDTH  write-back index.
- wb_data  in  DATA_WIDTH  write-back value.
- stall  out  1  hold IF/ID and bubble ID/EX.
- busy_mask  out  NUM_REGS  scoreboard state, bit i = register i has a pending write.

Behaviour:
- Reset (asynchronous, active-high): all registers go to 0 and busy_mask goes to 0 immediately, independent of clock. stall becomes 0 because no register is busy. rs_data and rt_data become 0 unless a write-back bypass is active.
- Register 0: reads always return 0. Writes to it are ignored. Its busy bit is never set, so it never stalls.
- Read path is combinational with zero latency:
  - rs_data = wb_data when wb_en, wb_addr==rs_addr and rs_addr!=0 (write-through bypass).
  - Otherwise rs_data = regs[rs_addr].
  - rt_data follows the same rule with rt_addr.
- Write: at posedge clock, if wb_en and wb_addr!=0, regs[wb_addr] <= wb_data.
- Hazard terms (wb_hit_x = wb_en && wb_addr==x):
  - raw_rs = rs_used && busy[rs_addr] && !wb_hit_rs.
  - raw_rt = rt_used && busy[rt_addr] && !wb_hit_rt.
  - waw = issue_dest_en && busy[issue_dest] && !wb_hit_dest.
  - stall = issue_valid && (raw_rs || raw_rt || waw). stall is purely combinational.
- Issue acceptance: accept = issue_valid && !stall.
- Scoreboard update at posedge clock:
  - Clear: if wb_en, busy[wb_addr] <= 0.
  - Set: if accept && issue_dest_en && issue_dest!=0, busy[issue_dest] <= 1.
  - When set and clear target the same index in the same cycle, set wins: the new producer is in flight and the old value has retired.
- Write-back to a register that is not busy is legal: the data is written and the busy bit is unchanged (stays 0).
- Because the WAW stall guarantees at most one in-flight producer per register, a single busy bit per register is sufficient.
- Reset asserted mid-operation clears all pending busy bits. Write-backs arriving after reset from pre-reset instructions are still written but cause no busy change.

Decomposition:
- Package mips_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - REG_ZERO = 0.
  - The reg_addr_t and word_t typedefs shared with the ID/EX and WB blocks.
- Sub-module reg_scoreboard contains the busy vector, set/clear logic and the stall computation.
- The top level holds the register array and the bypass muxes.

Test Plan:
- Reset, then wb_en=1 wb_addr=8 wb_data=0xDEADBEEF for one cycle; next cycle rs_addr=8 -> rs_data=0xDEADBEEF. Assert reset asynchronously -> rs_data=0 and busy_mask=0 before the next edge.
- Same-cycle bypass: wb_en=1 wb_addr=5 wb_data=0x12345678 with rt_addr=5 -> rt_data=0x12345678 in that same cycle, before the write commits.
- RAW stall: issue dest=3 accepted; next cycle rs_addr=3 rs_used=1 issue_valid=1 -> stall=1. Keep stall=1 until the cycle wb_en=1 wb_addr=3 wb_data=0x55, where stall=0 and rs_data=0x55.
- WAW: busy[7]=1, issue_dest_en=1 issue_dest=7 -> stall=1. Then write back 7 while re-issuing to 7 in the same cycle -> stall=0, and busy[7] remains 1 after the edge.
- Register 0: wb_en=1 wb_addr=0 wb_data=0xFFFFFFFF, then read rs_addr=0 -> 0. Issue dest=0 -> busy_mask=0, and a later read of reg 0 with rs_used=1 -> stall=0.
- Unused source: busy[9]=1, rt_addr=9 rt_used=0 issue_valid=1 -> stall=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared decode/write-back definitions: default widths, the hard-wired zero
// register index and the word/index types used across the operand path.
package mips_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int REG_ZERO       = 0;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/reg_scoreboard.sv
// In-order scoreboard: one busy bit per register, set on accepted issue and
// cleared on write-back, plus the RAW/WAW stall decision.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  input  logic                  rs_used,
  input  logic                  rt_used,
  input  logic                  issue_valid,
  input  logic                  issue_dest_en,
  input  logic [ADDR_WIDTH-1:0] issue_dest,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   busy_mask
);
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_raw_rs;
  logic                w_raw_rt;
  logic                w_waw;
  logic                w_accept;

  // A write-back landing this cycle resolves the hazard on its register.
  assign w_raw_rs = rs_used && r_busy[rs_addr] && !(wb_en && wb_addr == rs_addr);
  assign w_raw_rt = rt_used && r_busy[rt_addr] && !(wb_en && wb_addr == rt_addr);
  assign w_waw    = issue_dest_en && r_busy[issue_dest] && !(wb_en && wb_addr == issue_dest);

  // Handshake: issue_valid requests advance; the instruction is accepted in
  // the same cycle exactly when issue_valid is high and stall is low.
  assign stall    = issue_valid && (w_raw_rs || w_raw_rt || w_waw);
  assign w_accept = issue_valid && !stall;

  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_en) w_busy_nxt[wb_addr] = 1'b0;
    // Set after clear: a new producer outranks the retiring one.
    if (w_accept && issue_dest_en && issue_dest != ZERO_IDX)
      w_busy_nxt[issue_dest] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign busy_mask = r_busy;
endmodule

// File: rtl/id_regfile_hazard.sv
// Decode-stage register file: combinational reads with write-through bypass
// from WB, a clocked write port, and the scoreboard that generates stall.
module id_regfile_hazard
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  input  logic                  rs_used,
  input  logic                  rt_used,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  issue_valid,
  input  logic                  issue_dest_en,
  input  logic [ADDR_WIDTH-1:0] issue_dest,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   busy_mask
);
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (wb_en && wb_addr != ZERO_IDX) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Register 0 is forced to zero on read regardless of array contents.
  always_comb begin
    rs_data = '0;
    if (rs_addr != ZERO_IDX) begin
      if (wb_en && wb_addr == rs_addr) rs_data = wb_data;
      else                             rs_data = r_regs[rs_addr];
    end
  end

  always_comb begin
    rt_data = '0;
    if (rt_addr != ZERO_IDX) begin
      if (wb_en && wb_addr == rt_addr) rt_data = wb_data;
      else                             rt_data = r_regs[rt_addr];
    end
  end

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_used       (rs_used),
    .rt_used       (rt_used),
    .issue_valid   (issue_valid),
    .issue_dest_en (issue_dest_en),
    .issue_dest    (issue_dest),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .stall         (stall),
    .busy_mask     (busy_mask)
  );
endmodule

// File: tb/tb_id_regfile_hazard.sv
// Bench for id_regfile_hazard: directed hazard/bypass cases then random
// traffic, checked against a pending-producer list model via an expected queue.
module tb_id_regfile_hazard;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int W  = 2*DW + 1 + NR;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rs_addr = '0, rt_addr = '0, issue_dest = '0, wb_addr = '0;
  logic          rs_used = 1'b0, rt_used = 1'b0, issue_valid = 1'b0;
  logic          issue_dest_en = 1'b0, wb_en = 1'b0;
  logic [DW-1:0] wb_data = '0;
  logic [DW-1:0] rs_data, rt_data;
  logic          stall;
  logic [NR-1:0] busy_mask;

  id_regfile_hazard dut (
    .clock(clock), .reset(reset),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .rs_data(rs_data), .rt_data(rt_data),
    .issue_valid(issue_valid), .issue_dest_en(issue_dest_en), .issue_dest(issue_dest),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .busy_mask(busy_mask)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] m_regs [NR];
  int            pend_q [$];   // destinations with a producer in flight

  function automatic bit pending(input int a);
    foreach (pend_q[k]) if (pend_q[k] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_read(input int a);
    if (a == 0) return '0;
    if (wb_en && int'(wb_addr) == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit m_stall();
    bit hz;
    hz = 1'b0;
    if (rs_used && pending(rs_addr) && !(wb_en && wb_addr == rs_addr)) hz = 1'b1;
    if (rt_used && pending(rt_addr) && !(wb_en && wb_addr == rt_addr)) hz = 1'b1;
    if (issue_dest_en && pending(issue_dest) && !(wb_en && wb_addr == issue_dest)) hz = 1'b1;
    return issue_valid && hz;
  endfunction

  function automatic logic [NR-1:0] m_busy();
    logic [NR-1:0] m;
    m = '0;
    foreach (pend_q[k]) m[pend_q[k]] = 1'b1;
    return m;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    pend_q.delete();
  endfunction

  // Retire the written register, then record the newly accepted producer.
  function automatic void m_commit();
    bit acc;
    if (reset) return;
    acc = issue_valid && !m_stall();
    if (wb_en) begin
      for (int k = pend_q.size() - 1; k >= 0; k--)
        if (pend_q[k] == int'(wb_addr)) pend_q.delete(k);
      if (wb_addr != 0) m_regs[wb_addr] = wb_data;
    end
    if (acc && issue_dest_en && issue_dest != 0) pend_q.push_back(int'(issue_dest));
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  string        name_q [$];

  function automatic void push_exp(input string nm);
    exp_q.push_back({m_read(rs_addr), m_read(rt_addr), m_stall(), m_busy()});
    name_q.push_back(nm);
  endfunction

  task automatic chk(input string nm, input string fld, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so each queued expectation is
  // compared mid-low-phase of the cycle it was issued in.
  initial begin
    logic [W-1:0] e;
    string nm;
    forever begin
      @(negedge clock);
      #2;
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, "rs_data", rs_data, e[W-1 -: DW]);
        chk(nm, "rt_data", rt_data, e[W-DW-1 -: DW]);
        chk(nm, "stall", DW'(stall), DW'(e[NR]));
        chk(nm, "busy_mask", busy_mask, e[NR-1:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int rs, input int rt, input bit rsu, input bit rtu,
                      input bit iv, input bit den, input int dst,
                      input bit we, input int wa, input logic [DW-1:0] wd,
                      input string nm);
    @(negedge clock);
    rs_addr = AW'(rs); rt_addr = AW'(rt); rs_used = rsu; rt_used = rtu;
    issue_valid = iv; issue_dest_en = den; issue_dest = AW'(dst);
    wb_en = we; wb_addr = AW'(wa); wb_data = wd;
    push_exp(nm);
    m_commit();
  endtask

  task automatic idle(input string nm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0, nm);
  endtask

  // Reset raised mid-cycle, checked before the next rising edge.
  task automatic async_reset(input string nm);
    @(negedge clock);
    issue_valid = 1'b0; wb_en = 1'b0;
    #1 reset = 1'b1;
    m_reset();
    push_exp(nm);
    @(posedge clock);
    #3 reset = 1'b0;
  endtask

  initial begin
    int rs, rt, dst, wa;
    m_reset();
    idle("reset_state");
    @(posedge clock);
    #3 reset = 1'b0;

    // write then read back, then async reset clears data and busy bits
    step(0, 0, 0, 0, 0, 0, 0, 1, 8, 32'hDEADBEEF, "wb8");
    step(8, 0, 1, 0, 1, 1, 4, 0, 0, '0, "read8_issue4");
    step(8, 0, 1, 0, 0, 0, 0, 0, 0, '0, "read8_busy4");
    async_reset("async_reset");
    idle("post_reset");

    // same-cycle bypass on rt
    step(0, 5, 0, 1, 0, 0, 0, 1, 5, 32'h12345678, "bypass_rt5");
    step(0, 5, 0, 1, 0, 0, 0, 0, 0, '0, "read_rt5");

    // RAW on rs until the write-back arrives
    step(0, 0, 0, 0, 1, 1, 3, 0, 0, '0, "issue3");
    step(3, 0, 1, 0, 1, 0, 0, 0, 0, '0, "raw3_a");
    step(3, 0, 1, 0, 1, 0, 0, 0, 0, '0, "raw3_b");
    step(3, 0, 1, 0, 1, 0, 0, 1, 3, 32'h55, "raw3_wb");

    // WAW, then write-back and re-issue to the same register together
    step(0, 0, 0, 0, 1, 1, 7, 0, 0, '0, "issue7");
    step(0, 0, 0, 0, 1, 1, 7, 0, 0, '0, "waw7");
    step(0, 0, 0, 0, 1, 1, 7, 1, 7, 32'h77, "waw7_wb");
    step(7, 0, 1, 0, 1, 0, 0, 0, 0, '0, "busy7_kept");
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h777, "wb7");

    // register 0
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, "wb0");
    step(0, 0, 1, 0, 1, 1, 0, 0, 0, '0, "read0_issue0");
    step(0, 0, 1, 1, 1, 0, 0, 0, 0, '0, "read0_nostall");

    // unused source does not stall; write-back to idle register is legal
    step(0, 0, 0, 0, 1, 1, 9, 0, 0, '0, "issue9");
    step(0, 9, 0, 0, 1, 0, 0, 0, 0, '0, "unused_rt9");
    step(0, 9, 0, 1, 0, 0, 0, 1, 9, 32'h99, "wb9");
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, 32'hC0C0, "wb_idle12");
    step(12, 12, 1, 1, 1, 0, 0, 0, 0, '0, "read12");

    // random traffic with occasional mid-run resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        async_reset("rand_reset");
        continue;
      end
      rs  = (pend_q.size() > 0 && $urandom_range(0, 1)) ? pend_q[$urandom_range(0, pend_q.size()-1)] : $urandom_range(0, NR-1);
      rt  = (pend_q.size() > 0 && $urandom_range(0, 1)) ? pend_q[$urandom_range(0, pend_q.size()-1)] : $urandom_range(0, NR-1);
      dst = $urandom_range(0, 15);
      wa  = (pend_q.size() > 0 && $urandom_range(0, 3) != 0) ? pend_q[$urandom_range(0, pend_q.size()-1)] : $urandom_range(0, NR-1);
      step(rs, rt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), dst,
           1'($urandom_range(0, 1)), wa, $urandom(), "random");
    end

    idle("drain");
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
